// File: rtl/shared_bv_half_serializer_pkg.sv
// shared_bv_pkg: common types and helpers for the shared half-word serializer.
//   state_t      - serializer FSM states (IDLE, BEAT0, BEAT1)
//   half_select  - returns the low (sel=0) or high (sel=1) half of one share.
//                  Supports half widths up to MAX_HALF_WIDTH bits.
// No ports (package). Optional feature macro used by the slice:
// SHARED_BV_SERIALIZER_REFRESH_EN.
package shared_bv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    localparam int unsigned MAX_HALF_WIDTH = 32;
    localparam int unsigned PAD_WIDTH      = 2 * MAX_HALF_WIDTH;

    // Operates on one share only. The caller zero-extends the share to PAD_WIDTH
    // and truncates the result to its own half width.
    function automatic logic [MAX_HALF_WIDTH-1:0] half_select(
        input logic [PAD_WIDTH-1:0] word,
        input int unsigned          half_width,
        input logic                 sel
    );
        logic [PAD_WIDTH-1:0] shifted;
        logic [PAD_WIDTH-1:0] mask;
        shifted = sel ? (word >> half_width) : word;
        mask    = {{MAX_HALF_WIDTH{1'b0}}, {MAX_HALF_WIDTH{1'b1}}} >> (MAX_HALF_WIDTH - half_width);
        shifted = shifted & mask;
        return shifted[MAX_HALF_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/shared_bv_half_serializer_if.sv
// shared_bv_half_serializer_if: stream bundle between a full-width shared
// producer and a half-width shared consumer.
//   in_a        [NUM_SHARES][2*HALF_WIDTH] shared full-width word
//   in_a_valid  in_a holds a word
//   out_a_ready serializer accepts in_a this cycle
//   out_b       [NUM_SHARES][HALF_WIDTH] current shared half-word
//   out_b_valid out_b valid
//   out_b_last  second beat of a word
//   in_b_ready  downstream consumes out_b this cycle
//   in_random   [NUM_SHARES-1][HALF_WIDTH] fresh mask (SHARED_BV_SERIALIZER_REFRESH_EN only)
// Modports: master = producer/consumer side, slave = serializer side.
interface shared_bv_half_serializer_if #(
    parameter int unsigned NUM_SHARES = 2,
    parameter int unsigned HALF_WIDTH = 15
);
    logic [NUM_SHARES-1:0][2*HALF_WIDTH-1:0] in_a;
    logic                                    in_a_valid;
    logic                                    out_a_ready;
    logic [NUM_SHARES-1:0][HALF_WIDTH-1:0]   out_b;
    logic                                    out_b_valid;
    logic                                    out_b_last;
    logic                                    in_b_ready;
`ifdef SHARED_BV_SERIALIZER_REFRESH_EN
    logic [NUM_SHARES-2:0][HALF_WIDTH-1:0]   in_random;

    modport master (
        output in_a, in_a_valid, in_b_ready, in_random,
        input  out_a_ready, out_b, out_b_valid, out_b_last
    );
    modport slave (
        input  in_a, in_a_valid, in_b_ready, in_random,
        output out_a_ready, out_b, out_b_valid, out_b_last
    );
`else
    modport master (
        output in_a, in_a_valid, in_b_ready,
        input  out_a_ready, out_b, out_b_valid, out_b_last
    );
    modport slave (
        input  in_a, in_a_valid, in_b_ready,
        output out_a_ready, out_b, out_b_valid, out_b_last
    );
`endif
endinterface

// File: rtl/shared_bv_half_serializer_split.sv
// split_shared_bv: purely combinational per-share slicer.
//   word   [NUM_SHARES][2*HALF_WIDTH] input word
//   halves [2][NUM_SHARES][HALF_WIDTH] halves[0] = low halves, halves[1] = high halves
// Each share is sliced on its own; shares are never combined.
module split_shared_bv
    import shared_bv_pkg::*;
#(
    parameter int unsigned NUM_SHARES = 2,
    parameter int unsigned HALF_WIDTH = 15
) (
    input  logic [NUM_SHARES-1:0][2*HALF_WIDTH-1:0]     word,
    output logic [1:0][NUM_SHARES-1:0][HALF_WIDTH-1:0]  halves
);
    always_comb begin
        halves = '0;
        for (int unsigned i = 0; i < NUM_SHARES; i++) begin
            halves[0][i] = HALF_WIDTH'(half_select(PAD_WIDTH'(word[i]), HALF_WIDTH, 1'b0));
            halves[1][i] = HALF_WIDTH'(half_select(PAD_WIDTH'(word[i]), HALF_WIDTH, 1'b1));
        end
    end
endmodule

// File: rtl/shared_bv_half_serializer.sv
// shared_bv_half_serializer: takes one masked full-width word and emits it as
// two masked half-words on consecutive output beats (HI_FIRST picks the order).
//   in_clock    rising-edge clock
//   in_reset_n  asynchronous active-low reset
//   bus         shared_bv_half_serializer_if.slave (in_a/valid/ready, out_b/valid/last/ready)
// Optional: SHARED_BV_SERIALIZER_REFRESH_EN remasks each half with in_random
// as it is loaded into out_b; the unshared value is unchanged.
module shared_bv_half_serializer
    import shared_bv_pkg::*;
#(
    parameter int unsigned NUM_SHARES = 2,
    parameter int unsigned HALF_WIDTH = 15,
    parameter int unsigned HI_FIRST   = 0
) (
    input logic                        in_clock,
    input logic                        in_reset_n,
    shared_bv_half_serializer_if.slave bus
);
    localparam int unsigned BIT_WIDTH = 2 * HALF_WIDTH;
    localparam logic        FIRST_SEL = (HI_FIRST != 0);

    state_t                                       state;
    logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]         word_q;
    logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]         split_in;
    logic [1:0][NUM_SHARES-1:0][HALF_WIDTH-1:0]   halves;
    logic [NUM_SHARES-1:0][HALF_WIDTH-1:0]        load_half;
    logic [NUM_SHARES-1:0][HALF_WIDTH-1:0]        out_b_q;
    logic                                         out_b_valid_q;
    logic                                         out_b_last_q;
    logic                                         a_ready;
    logic                                         accept;
`ifdef SHARED_BV_SERIALIZER_REFRESH_EN
    logic [HALF_WIDTH-1:0]                        rnd_acc;
`endif

    assign a_ready = (state == IDLE) || ((state == BEAT1) && bus.in_b_ready);
    assign accept  = a_ready && bus.in_a_valid;

    // One splitter serves both beats: it sees the held word while advancing
    // from BEAT0, and the incoming word on every edge that can capture one.
    assign split_in = (state == BEAT0) ? word_q : bus.in_a;

    split_shared_bv #(
        .NUM_SHARES (NUM_SHARES),
        .HALF_WIDTH (HALF_WIDTH)
    ) u_split (
        .word   (split_in),
        .halves (halves)
    );

    always_comb begin
        load_half = halves[(state == BEAT0) ? ~FIRST_SEL : FIRST_SEL];
`ifdef SHARED_BV_SERIALIZER_REFRESH_EN
        // Last share absorbs the XOR of all masks so the shares still recombine
        // to the same unshared half.
        rnd_acc = '0;
        for (int unsigned j = 0; j < NUM_SHARES - 1; j++) begin
            load_half[j] = load_half[j] ^ bus.in_random[j];
            rnd_acc      = rnd_acc ^ bus.in_random[j];
        end
        load_half[NUM_SHARES-1] = load_half[NUM_SHARES-1] ^ rnd_acc;
`endif
    end

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state         <= IDLE;
            word_q        <= '0;
            out_b_q       <= '0;
            out_b_valid_q <= 1'b0;
            out_b_last_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        word_q        <= bus.in_a;
                        out_b_q       <= load_half;
                        out_b_valid_q <= 1'b1;
                        out_b_last_q  <= 1'b0;
                        state         <= BEAT0;
                    end
                end
                BEAT0: begin
                    if (bus.in_b_ready) begin
                        out_b_q      <= load_half;
                        out_b_last_q <= 1'b1;
                        state        <= BEAT1;
                    end
                end
                BEAT1: begin
                    if (bus.in_b_ready) begin
                        if (bus.in_a_valid) begin
                            word_q        <= bus.in_a;
                            out_b_q       <= load_half;
                            out_b_valid_q <= 1'b1;
                            out_b_last_q  <= 1'b0;
                            state         <= BEAT0;
                        end else begin
                            out_b_valid_q <= 1'b0;
                            out_b_last_q  <= 1'b0;
                            state         <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.out_a_ready = a_ready;
    assign bus.out_b       = out_b_q;
    assign bus.out_b_valid = out_b_valid_q;
    assign bus.out_b_last  = out_b_last_q;
endmodule

// File: tb/tb_shared_bv_half_serializer.sv
// Testbench for shared_bv_half_serializer (NUM_SHARES=2, HALF_WIDTH=15).
// dut0 uses HI_FIRST=0, dut1 uses HI_FIRST=1. Works with or without
// SHARED_BV_SERIALIZER_REFRESH_EN.
module tb_shared_bv_half_serializer;
    localparam int NS = 2;
    localparam int HW = 15;
    localparam int BW = 30;
`ifdef SHARED_BV_SERIALIZER_REFRESH_EN
    localparam bit REFRESH = 1'b1;
`else
    localparam bit REFRESH = 1'b0;
`endif

    typedef logic [NS-1:0][HW-1:0] half_t;
    typedef logic [NS-1:0][BW-1:0] word_t;
    typedef logic [NS-2:0][HW-1:0] rnd_t;
    typedef struct packed {
        half_t data;
        logic  last;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total  = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    shared_bv_half_serializer_if #(.NUM_SHARES(NS), .HALF_WIDTH(HW)) bus0 ();
    shared_bv_half_serializer_if #(.NUM_SHARES(NS), .HALF_WIDTH(HW)) bus1 ();

    shared_bv_half_serializer #(.NUM_SHARES(NS), .HALF_WIDTH(HW), .HI_FIRST(0)) dut0 (
        .in_clock   (clk),
        .in_reset_n (rst_n),
        .bus        (bus0)
    );
    shared_bv_half_serializer #(.NUM_SHARES(NS), .HALF_WIDTH(HW), .HI_FIRST(1)) dut1 (
        .in_clock   (clk),
        .in_reset_n (rst_n),
        .bus        (bus1)
    );

    // Reference: half k of each share is bits [HW*k +: HW], nothing else.
    function automatic half_t plain_half(word_t w, int k);
        half_t h;
        for (int i = 0; i < NS; i++) h[i] = HW'(w[i] >> (HW * k));
        return h;
    endfunction

    function automatic half_t remask(half_t h, rnd_t r);
        half_t         m;
        logic [HW-1:0] acc;
        m   = h;
        acc = '0;
        if (REFRESH) begin
            for (int j = 0; j < NS - 1; j++) begin
                m[j] = m[j] ^ r[j];
                acc  = acc ^ r[j];
            end
            m[NS-1] = m[NS-1] ^ acc;
        end
        return m;
    endfunction

    function automatic logic [HW-1:0] xor_all(half_t h);
        logic [HW-1:0] x;
        x = '0;
        for (int i = 0; i < NS; i++) x = x ^ h[i];
        return x;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input half_t obs, input half_t plain, input rnd_t r);
        chk({tag, "_data"}, 64'(obs), 64'(remask(plain, r)));
        chk({tag, "_xor"}, 64'(xor_all(obs)), 64'(xor_all(plain)));
    endtask

    task automatic drive_rnd(input rnd_t r);
`ifdef SHARED_BV_SERIALIZER_REFRESH_EN
        bus0.in_random = r;
        bus1.in_random = r;
`else
        if (r != r) $display("unreachable");
`endif
    endtask

    word_t w_single;
    word_t w;
    word_t wq[4];
    rnd_t  rnd;
    beat_t pend[$];
    beat_t b;
    half_t cur;
    logic  r_valid, r_ready, exp_ready, had, popped, pv_hold;

    initial begin
        w_single[0] = {15'h1234, 15'h0ABC};
        w_single[1] = {15'h0F0F, 15'h7000};
        rnd = 15'h5A5A;
        drive_rnd(rnd);
        bus0.in_a = '0; bus0.in_a_valid = 1'b0; bus0.in_b_ready = 1'b0;
        bus1.in_a = '0; bus1.in_a_valid = 1'b0; bus1.in_b_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_b0", 64'(bus0.out_b), 64'd0);
        chk("rst_valid0", 64'(bus0.out_b_valid), 64'd0);
        chk("rst_last0", 64'(bus0.out_b_last), 64'd0);
        chk("rst_ready0", 64'(bus0.out_a_ready), 64'd1);
        chk("rst_out_b1", 64'(bus1.out_b), 64'd0);
        chk("rst_valid1", 64'(bus1.out_b_valid), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word, lower half first
        bus0.in_a = w_single; bus0.in_a_valid = 1'b1; bus0.in_b_ready = 1'b1;
        #1 chk("sw_idle_ready", 64'(bus0.out_a_ready), 64'd1);
        @(negedge clk);
        bus0.in_a_valid = 1'b0;
        chk_beat("sw_b0", bus0.out_b, {15'h7000, 15'h0ABC}, rnd);
        chk("sw_b0_unshared", 64'(xor_all(bus0.out_b)), 64'h7ABC);
        chk("sw_b0_valid", 64'(bus0.out_b_valid), 64'd1);
        chk("sw_b0_last", 64'(bus0.out_b_last), 64'd0);
        #1 chk("sw_b0_ready", 64'(bus0.out_a_ready), 64'd0);
        @(negedge clk);
        chk_beat("sw_b1", bus0.out_b, {15'h0F0F, 15'h1234}, rnd);
        chk("sw_b1_unshared", 64'(xor_all(bus0.out_b)), 64'h1D3B);
        chk("sw_b1_valid", 64'(bus0.out_b_valid), 64'd1);
        chk("sw_b1_last", 64'(bus0.out_b_last), 64'd1);
        @(negedge clk);
        chk("sw_end_valid", 64'(bus0.out_b_valid), 64'd0);
        chk("sw_end_last", 64'(bus0.out_b_last), 64'd0);
        chk("sw_end_ready", 64'(bus0.out_a_ready), 64'd1);

        // Backpressure during BEAT0 for 3 cycles
        for (int i = 0; i < NS; i++) w[i] = BW'($urandom);
        bus0.in_a = w; bus0.in_a_valid = 1'b1; bus0.in_b_ready = 1'b0;
        @(negedge clk);
        bus0.in_a_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            chk_beat("bp_hold", bus0.out_b, plain_half(w, 0), rnd);
            chk("bp_hold_valid", 64'(bus0.out_b_valid), 64'd1);
            chk("bp_hold_last", 64'(bus0.out_b_last), 64'd0);
            chk("bp_hold_ready", 64'(bus0.out_a_ready), 64'd0);
        end
        bus0.in_b_ready = 1'b1;
        @(negedge clk);
        chk_beat("bp_b1", bus0.out_b, plain_half(w, 1), rnd);
        chk("bp_b1_last", 64'(bus0.out_b_last), 64'd1);
        @(negedge clk);
        chk("bp_end_valid", 64'(bus0.out_b_valid), 64'd0);

        // Back-to-back: 4 words, 8 beats
        for (int n = 0; n < 4; n++)
            for (int i = 0; i < NS; i++) wq[n][i] = BW'($urandom);
        bus0.in_a = wq[0]; bus0.in_a_valid = 1'b1; bus0.in_b_ready = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 8; c++) begin
            chk_beat("b2b", bus0.out_b, plain_half(wq[c / 2], c % 2), rnd);
            chk("b2b_valid", 64'(bus0.out_b_valid), 64'd1);
            chk("b2b_last", 64'(bus0.out_b_last), 64'(c % 2));
            chk("b2b_ready", 64'(bus0.out_a_ready), 64'(c % 2));
            if (c % 2 == 1) begin
                if (c / 2 + 1 < 4) bus0.in_a = wq[c / 2 + 1];
                else bus0.in_a_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("b2b_end_valid", 64'(bus0.out_b_valid), 64'd0);

        // Randomized traffic against a queue model of pending beats
        pend.delete();
        pv_hold = 1'b0;
        r_valid = 1'b0;
        w = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pv_hold) begin
                r_valid = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < NS; i++) w[i] = BW'($urandom);
            end
            r_ready = ($urandom_range(0, 3) != 0);
            rnd = HW'($urandom);
            bus0.in_a = w; bus0.in_a_valid = r_valid; bus0.in_b_ready = r_ready;
            drive_rnd(rnd);
            exp_ready = (pend.size() == 0) || (pend.size() == 1 && r_ready);
            #1 chk("rnd_a_ready", 64'(bus0.out_a_ready), 64'(exp_ready));
            @(negedge clk);
            had    = (pend.size() > 0);
            popped = 1'b0;
            if (had && r_ready) begin
                void'(pend.pop_front());
                popped = 1'b1;
            end
            if (r_valid && exp_ready) begin
                b.data = plain_half(w, 0); b.last = 1'b0; pend.push_back(b);
                b.data = plain_half(w, 1); b.last = 1'b1; pend.push_back(b);
            end
            if (pend.size() > 0 && (!had || popped)) cur = remask(pend[0].data, rnd);
            pv_hold = r_valid && !exp_ready;
            chk("rnd_valid", 64'(bus0.out_b_valid), 64'(pend.size() > 0));
            if (pend.size() > 0) begin
                chk("rnd_data", 64'(bus0.out_b), 64'(cur));
                chk("rnd_last", 64'(bus0.out_b_last), 64'(pend[0].last));
            end
        end
        bus0.in_a_valid = 1'b0; bus0.in_b_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("drain_valid", 64'(bus0.out_b_valid), 64'd0);

        // HI_FIRST=1: upper halves first
        rnd = 15'h5A5A;
        drive_rnd(rnd);
        bus1.in_a = w_single; bus1.in_a_valid = 1'b1; bus1.in_b_ready = 1'b1;
        @(negedge clk);
        bus1.in_a_valid = 1'b0;
        chk_beat("hf_b0", bus1.out_b, {15'h0F0F, 15'h1234}, rnd);
        chk("hf_b0_last", 64'(bus1.out_b_last), 64'd0);
        @(negedge clk);
        chk_beat("hf_b1", bus1.out_b, {15'h7000, 15'h0ABC}, rnd);
        chk("hf_b1_last", 64'(bus1.out_b_last), 64'd1);
        @(negedge clk);
        chk("hf_end_valid", 64'(bus1.out_b_valid), 64'd0);

        // Reset in the middle of a word
        for (int i = 0; i < NS; i++) w[i] = BW'($urandom);
        bus1.in_a = w; bus1.in_a_valid = 1'b1; bus1.in_b_ready = 1'b0;
        @(negedge clk);
        bus1.in_a_valid = 1'b0;
        chk("mr_pre_valid", 64'(bus1.out_b_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_async_out_b", 64'(bus1.out_b), 64'd0);
        chk("mr_async_valid", 64'(bus1.out_b_valid), 64'd0);
        chk("mr_async_last", 64'(bus1.out_b_last), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus1.in_b_ready = 1'b1;
        @(negedge clk);
        chk("mr_post_valid", 64'(bus1.out_b_valid), 64'd0);
        chk("mr_post_last", 64'(bus1.out_b_last), 64'd0);
        chk("mr_post_ready", 64'(bus1.out_a_ready), 64'd1);
        @(negedge clk);
        chk("mr_post_valid2", 64'(bus1.out_b_valid), 64'd0);
        chk("mr_post_out_b", 64'(bus1.out_b), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/shared_bv_half_serializer.md
Name: shared_bv_half_serializer

Overview:
- Streaming inverse of the shared half-word join: accepts one masked full-width word (NUM_SHARES shares, each BIT_WIDTH = 2*HALF_WIDTH bits) and emits it as two masked half-words over two output beats.
- Used where a full-width shared datapath feeds a half-width shared unit, e.g. 15-bit tower-field stages.
- Shares are never combined. Each share is registered and sliced independently.

Parameters:
- NUM_SHARES, 2, number of Boolean shares per value.
- HALF_WIDTH, 15, bits per share in one output half; BIT_WIDTH = 2*HALF_WIDTH is a localparam.
- HI_FIRST, 0, 0 = emit bits [HALF_WIDTH-1:0] first; 1 = emit upper half first.

Ports:
- in_clock  input  1  clock; all state changes on rising edge.
- in_reset_n  input  1  asynchronous active-low reset.
- in_a  input  [NUM_SHARES-1:0][BIT_WIDTH-1:0]  shared full-width word.
- in_a_valid  input  1  in_a holds a word.
- out_a_ready  output  1  block accepts in_a this cycle.
- out_b  output  [NUM_SHARES-1:0][HALF_WIDTH-1:0]  current shared half-word (registered).
- out_b_valid  output  1  out_b valid.
- out_b_last  output  1  high on the second beat of a word.
- in_b_ready  input  1  downstream consumes out_b this cycle.

Behaviour:
- Reset:
  - Asynchronous, active-low. Whenever in_reset_n = 0: state = IDLE, out_b = 0, out_b_valid = 0, out_b_last = 0, word register cleared to 0.
  - A reset in the middle of a word discards that word; no partial beat is emitted after reset.
- States:
  - IDLE: nothing held.
  - BEAT0: first half presented.
  - BEAT1: second half presented.
- out_a_ready is combinational: 1 in IDLE, or in BEAT1 when in_b_ready = 1. Otherwise 0.
- Accept: in_a_valid & out_a_ready at a rising edge captures all shares of in_a into the word register and goes to BEAT0.
  - First half (lower half, or upper half if HI_FIRST) is loaded into out_b.
  - Set out_b_valid = 1, out_b_last = 0.
  - Latency: in_a accepted in cycle N appears on out_b in cycle N+1.
- BEAT0, in_b_ready = 1: load the other half into out_b, set out_b_last = 1, go to BEAT1.
- BEAT0, in_b_ready = 0: hold all outputs.
- BEAT1, in_b_ready = 1, in_a_valid = 1: accept the new word in the same edge and go to BEAT0 with its first half (back-to-back, 1 word per 2 cycles).
- BEAT1, in_b_ready = 1, in_a_valid = 0: go to IDLE, out_b_valid = 0, out_b_last = 0. out_b keeps its last value (don't care).
- BEAT1, in_b_ready = 0: hold all outputs.
- Output stability: out_b, out_b_valid and out_b_last never change while out_b_valid = 1 and in_b_ready = 0.
- in_a is ignored whenever out_a_ready = 0. The upstream producer must hold it.
- Slicing per share i:
  - low = in_a[i][HALF_WIDTH-1:0]
  - high = in_a[i][BIT_WIDTH-1:HALF_WIDTH]
  - No arithmetic and no cross-share logic.

Optional Feature:
- Macro: SHARED_BV_SERIALIZER_REFRESH_EN.
- Defined:
  - Adds input in_random [NUM_SHARES-2:0][HALF_WIDTH-1:0].
  - Each emitted half is remasked when it is loaded into out_b: share j ^= in_random[j] for j < NUM_SHARES-1; the last share ^= XOR of all in_random words.
  - The unshared value is unchanged.
  - in_random is sampled only on edges that load out_b. It must be fresh for each beat.
- Undefined: no in_random port; halves are passed through unmodified.

Decomposition:
- Package shared_bv_pkg:
  - state enum (IDLE, BEAT0, BEAT1);
  - helper function half_select(word, sel) for per-share slicing.
- Sub-module split_shared_bv: purely combinational, [NUM_SHARES][BIT_WIDTH] -> [1:0][NUM_SHARES][HALF_WIDTH]. Instantiated once to produce both halves.
- Refresh logic stays inline, guarded by the macro.

Test Plan (NUM_SHARES=2, HALF_WIDTH=15, HI_FIRST=0):
- Single word: in_a[0]={15'h1234,15'h0ABC}, in_a[1]={15'h0F0F,15'h7000}, in_b_ready=1.
  - Next cycle: out_b={15'h7000,15'h0ABC}, last=0.
  - Following cycle: out_b={15'h0F0F,15'h1234}, last=1.
  - Then valid=0 and out_a_ready=1.
- Backpressure: hold in_b_ready=0 for 3 cycles during BEAT0.
  - out_b, valid and last remain constant; out_a_ready=0.
  - Release: second beat follows on the next edge.
- Back-to-back: in_a_valid held high with 4 distinct words, in_b_ready=1.
  - 8 consecutive valid beats, last alternating 0,1.
  - out_a_ready high every second cycle.
- HI_FIRST=1 with the single-word stimulus: first beat carries the high halves {15'h0F0F,15'h1234}.
- Reset mid-word: assert in_reset_n=0 during BEAT0.
  - Outputs are 0 immediately (asynchronous).
  - After release: IDLE, no stale beat emitted.
- Refresh enabled: in_random=15'h5A5A on both beats.
  - Share0 XOR share1 of each beat equals the original unshared half (0x7ABC, then 0x1D3B).
  - Each share differs from the pass-through value by 0x5A5A.
